phy_mem_ctrl: RTL and testbench
===============================

PHY_MEM_CTRL -- requirements
Module: phy_mem_ctrl

Sits directly downstream of the MMU. Serves physical addresses from the MMU with on-board SRAM and memory-mapped UART registers.

Interface
REQ-001 Parameters (name, default, meaning):
- WE_CYCLES, 2: SRAM write-enable low time, in clocks, range 1..7.
- TX_DEPTH, 4: UART TX FIFO entries, power of two, range 2..16.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on posedge.
- rst, in, 1: synchronous, active-high reset.
- dev_mem_addr, in, 32: physical byte address from MMU.
- dev_mem_data_in, in, 32: write data from MMU.
- dev_mem_data_out, out, 32: read data to MMU, combinational.
- dev_mem_is_write, in, 1: write request, asserted for exactly one cycle.
- dev_mem_busy, out, 1: controller busy; MMU must stall.
- ram_addr, out, 20: SRAM word address.
- ram_data, inout, 32: SRAM data bus.
- ram_ce_n, out, 1: SRAM chip enable, active low.
- ram_oe_n, out, 1: SRAM output enable, active low.
- ram_we_n, out, 1: SRAM write enable, active low.
- uart_tx_data, out, 8: byte to transmitter.
- uart_tx_start, out, 1: one-cycle start pulse to transmitter.
- uart_tx_busy, in, 1: transmitter busy.
- uart_rx_data, in, 8: received byte.
- uart_rx_valid, in, 1: one-cycle pulse; uart_rx_data is valid.

Function
REQ-003 Address decode:
- SRAM: 0x00000000-0x003FFFFF, with ram_addr = addr[21:2].
- UART_DATA: 0x1FD003F8.
- UART_STAT: 0x1FD003FC.
- All other addresses are unmapped.
REQ-004 States are IDLE, WR_PULSE, WR_RECOVER and TX_WAIT; dev_mem_busy SHALL equal (state != IDLE), registered, never combinational from inputs.
REQ-005 In IDLE with dev_mem_is_write=0, reads complete in the same cycle:
- SRAM: ce_n=0, oe_n=0, we_n=1, ram_data tri-stated, dev_mem_data_out = ram_data.
- UART_DATA: dev_mem_data_out = {24'b0, rx_byte}.
- UART_STAT: dev_mem_data_out = {30'b0, rx_ready, tx_not_full}.
- Unmapped: dev_mem_data_out = 0 and ce_n=1.
REQ-006 In IDLE with dev_mem_is_write=1, the controller SHALL latch the address and data at posedge; the MMU does not hold them afterwards.
REQ-007 Write to SRAM:
- Next state is WR_PULSE, held WE_CYCLES clocks.
- During WR_PULSE: ce_n=0, we_n=0, oe_n=1; ram_data is driven with the latched data; ram_addr comes from the latched address.
- Then WR_RECOVER for 1 clock: we_n=1, ce_n=0, ram_data still driven.
- Then IDLE.
REQ-008 Write to UART_DATA:
- FIFO not full: enqueue the latched byte [7:0] at that posedge and remain in IDLE; busy stays 0.
- FIFO full: go to TX_WAIT and hold busy until a pop frees a slot, then enqueue and return to IDLE.
REQ-009 Writes to UART_STAT or unmapped addresses SHALL be ignored with no state change.
REQ-010 dev_mem_is_write while state != IDLE is a protocol violation and SHALL be ignored.
REQ-011 In any state other than IDLE, dev_mem_data_out SHALL be 0 and reads are not serviced.
REQ-012 TX drain: when the FIFO is non-empty, uart_tx_busy=0 and uart_tx_start was 0 in the previous cycle, the controller SHALL:
- drive uart_tx_start=1 for one cycle with uart_tx_data = head byte;
- pop the FIFO at that posedge.
REQ-013 Simultaneous enqueue and pop SHALL both take effect and leave the count unchanged. FIFO pointers SHALL wrap modulo TX_DEPTH. tx_not_full = (count != TX_DEPTH).
REQ-014 RX capture:
- uart_rx_valid=1 latches rx_byte <= uart_rx_data and sets rx_ready.
- A read of UART_DATA in IDLE clears rx_ready at that posedge.
- rx_valid arriving in the same cycle as a clearing read wins: the new byte is latched and rx_ready stays 1.
- An unread byte is overwritten silently.
- A UART_DATA read with rx_ready=0 returns the stale rx_byte and has no effect.

Reset
REQ-015 When rst=1 at posedge, the controller SHALL:
- go to state IDLE;
- clear the FIFO pointers and count;
- set rx_byte=0, rx_ready=0, uart_tx_start=0, dev_mem_busy=0;
- set ram_we_n=1 and tri-state ram_data.
REQ-016 Reset during WR_PULSE SHALL deassert ram_we_n in the cycle following that posedge; the interrupted write is abandoned.

Verification
REQ-017 SRAM write then read, with WE_CYCLES=2: write 0xDEADBEEF to 0x00000010 -> ram_addr=0x00004, we_n low exactly 2 clocks, busy high 3 clocks; a subsequent read of 0x00000010 returns 0xDEADBEEF in the same cycle.
REQ-018 UART TX with uart_tx_busy=0: write 0x41 then 0x42 to 0x1FD003F8 -> busy stays 0; two tx_start pulses, not on adjacent cycles, with data 0x41 then 0x42.
REQ-019 FIFO full: with uart_tx_busy=1, write 5 bytes -> after the 4th, UART_STAT bit0=0; the 5th write holds busy; releasing tx_busy emits the bytes in order, then busy drops.
REQ-020 RX: uart_rx_valid with 0x5A -> UART_STAT reads 0x2 (with FIFO full; 0x3 otherwise); read UART_DATA returns 0x5A and clears bit1; rx_valid in the same cycle as the clearing read keeps bit1=1.
REQ-021 Reset mid-write: assert rst during WR_PULSE -> we_n=1 and busy=0 the next cycle; unmapped read of 0x20000000 returns 0.

Source files
------------

// File: rtl/phy_mem_ctrl.sv
// Physical memory controller behind the MMU.
// Serves SRAM and memory-mapped UART data/status registers.
module phy_mem_ctrl #(
  parameter int WE_CYCLES = 2,
  parameter int TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dev_mem_addr,
  input  logic [31:0] dev_mem_data_in,
  output logic [31:0] dev_mem_data_out,
  input  logic        dev_mem_is_write,
  output logic        dev_mem_busy,
  output logic [19:0] ram_addr,
  inout  wire  [31:0] ram_data,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = $clog2(TX_DEPTH + 1);
  localparam logic [31:0] UART_DATA = 32'h1FD0_03F8;
  localparam logic [31:0] UART_STAT = 32'h1FD0_03FC;

  typedef enum logic [1:0] {
    IDLE,
    WR_PULSE,
    WR_RECOVER,
    TX_WAIT
  } state_t;

  state_t         state, state_n;
  logic [2:0]     we_cnt, we_cnt_n;
  logic [19:0]    lat_addr;
  logic [31:0]    lat_data;
  logic           latch;

  logic [7:0]     fifo_mem [TX_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push, pop;
  logic [7:0]     push_byte;
  logic           start_q;

  logic [7:0]     rx_byte;
  logic           rx_ready;

  logic           idle, rd;
  logic           sel_sram, sel_data, sel_stat;
  logic           wr_phase;

  assign idle     = (state == IDLE);
  assign rd       = idle && !dev_mem_is_write;
  assign sel_sram = (dev_mem_addr[31:22] == 10'd0);
  assign sel_data = (dev_mem_addr == UART_DATA);
  assign sel_stat = (dev_mem_addr == UART_STAT);
  assign wr_phase = (state == WR_PULSE) || (state == WR_RECOVER);

  assign full = (count == CW'(TX_DEPTH));

  // start needs a quiet cycle between pulses so the transmitter can raise busy
  assign uart_tx_start = !rst && (count != '0) && !uart_tx_busy && !start_q;
  assign pop           = uart_tx_start;
  assign uart_tx_data  = fifo_mem[rd_ptr];

  assign dev_mem_busy = !idle;

  always_comb begin
    state_n   = state;
    we_cnt_n  = we_cnt;
    latch     = 1'b0;
    push      = 1'b0;
    push_byte = dev_mem_data_in[7:0];
    unique case (state)
      IDLE: begin
        if (dev_mem_is_write) begin
          if (sel_sram) begin
            state_n  = WR_PULSE;
            we_cnt_n = 3'(WE_CYCLES - 1);
            latch    = 1'b1;
          end else if (sel_data) begin
            if (!full || pop) begin
              push = 1'b1;
            end else begin
              state_n = TX_WAIT;
              latch   = 1'b1;
            end
          end
        end
      end
      WR_PULSE: begin
        if (we_cnt == 3'd0) state_n = WR_RECOVER;
        else we_cnt_n = we_cnt - 3'd1;
      end
      WR_RECOVER: state_n = IDLE;
      TX_WAIT: begin
        if (pop) begin
          push      = 1'b1;
          push_byte = lat_data[7:0];
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = idle ? dev_mem_addr[21:2] : lat_addr;
    ram_ce_n = !((rd && sel_sram) || wr_phase);
    ram_oe_n = !(rd && sel_sram);
    ram_we_n = (state != WR_PULSE);
  end

  assign ram_data = wr_phase ? lat_data : 'z;

  always_comb begin
    dev_mem_data_out = '0;
    if (rd) begin
      unique case (1'b1)
        sel_sram: dev_mem_data_out = ram_data;
        sel_data: dev_mem_data_out = {24'd0, rx_byte};
        sel_stat: dev_mem_data_out = {30'd0, rx_ready, !full};
        default:  dev_mem_data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_cnt   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      start_q  <= 1'b0;
      rx_byte  <= '0;
      rx_ready <= 1'b0;
    end else begin
      state   <= state_n;
      we_cnt  <= we_cnt_n;
      start_q <= uart_tx_start;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // a fresh byte beats a clearing read in the same cycle
      if (uart_rx_valid) begin
        rx_byte  <= uart_rx_data;
        rx_ready <= 1'b1;
      end else if (rd && sel_data) begin
        rx_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      lat_addr <= dev_mem_addr[21:2];
      lat_data <= dev_mem_data_in;
    end
    if (push && !rst) fifo_mem[wr_ptr] <= push_byte;
  end

endmodule

// File: tb/tb_phy_mem_ctrl.sv
// Bench for phy_mem_ctrl: SRAM and UART models plus
// a transaction-level reference (queues, word map, rx state).
module tb_phy_mem_ctrl;

  localparam logic [31:0] UART_DATA = 32'h1FD0_03F8;
  localparam logic [31:0] UART_STAT = 32'h1FD0_03FC;
  localparam logic [31:0] IDLE_A    = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din;
  logic        is_write;
  logic [31:0] dout;
  logic        busy;
  logic [19:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ce_n, oe_n, we_n;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        hold;
  logic [1:0]  tx_cnt = 2'd0;
  logic [7:0]  rx_data;
  logic        rx_valid;

  wire uart_tx_busy = hold | (tx_cnt != 2'd0);

  phy_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .dev_mem_addr(addr), .dev_mem_data_in(din),
    .dev_mem_data_out(dout), .dev_mem_is_write(is_write),
    .dev_mem_busy(busy), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_ce_n(ce_n),
    .ram_oe_n(oe_n), .ram_we_n(we_n),
    .uart_tx_data(tx_data), .uart_tx_start(tx_start),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(rx_data),
    .uart_rx_valid(rx_valid)
  );

  initial forever #5 clk = ~clk;

  logic [31:0] sram [0:4095];
  assign ram_data = (!ce_n && !oe_n && we_n) ? sram[ram_addr[11:0]] : 'z;
  always @(posedge clk) begin
    if (!ce_n && !we_n) sram[ram_addr[11:0]] <= ram_data;
  end

  logic [7:0] got_tx [$];
  logic [7:0] exp_tx [$];
  logic       prev_seen = 1'b0;
  logic       started = 1'b0;
  int         adj_viol = 0;

  always begin
    @(negedge clk);
    #2;
    if (tx_start) begin
      got_tx.push_back(tx_data);
      if (prev_seen) adj_viol++;
    end
    prev_seen = tx_start;
    started   = tx_start;
  end

  always @(posedge clk) begin
    if (started) tx_cnt <= 2'($urandom_range(0, 3));
    else if (tx_cnt != 2'd0) tx_cnt <= tx_cnt - 2'd1;
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [int];
  logic [7:0]  rx_byte_ref;
  logic        rx_rdy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; din = d; is_write = 1'b1;
    @(negedge clk);
    is_write = 1'b0; addr = IDLE_A; din = $urandom;
    if (a == UART_DATA) exp_tx.push_back(d[7:0]);
    if (a[31:22] == 10'd0) ref_mem[int'(a[21:2])] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
    @(negedge clk);
    addr = a;
    #1;
    chk(tag, dout, exp);
    @(negedge clk);
    addr = IDLE_A;
  endtask

  task automatic drain();
    int n = 0;
    while (got_tx.size() < exp_tx.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    cyc(10);
    chk("drain_count", 32'(got_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
      chk("tx_byte", {24'd0, got_tx[i]}, {24'd0, exp_tx[i]});
    got_tx.delete();
    exp_tx.delete();
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0]  b;
    int          bcnt, wcnt, same;

    rst = 1'b1; hold = 1'b0; addr = IDLE_A; din = '0;
    is_write = 1'b0; rx_data = '0; rx_valid = 1'b0;
    cyc(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    rst = 1'b0;
    rx_byte_ref = '0; rx_rdy = 1'b0;
    rdchk("rst_stat", UART_STAT, 32'h1);
    rdchk("rst_rxbyte", UART_DATA, 32'h0);
    rdchk("unmapped", IDLE_A, 32'h0);

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    chk("wr_ram_addr", {12'd0, ram_addr}, 32'h4);
    chk("wr_ram_data", ram_data, 32'hDEAD_BEEF);
    addr = UART_STAT;
    #1;
    chk("busy_dout", dout, 32'h0);
    chk("busy_oe_n", {31'd0, oe_n}, 32'd1);
    bcnt = 0; wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bcnt++;
      if (!we_n) wcnt++;
      if (i == 2) begin
        chk("recov_ce_n", {31'd0, ce_n}, 32'd0);
        chk("recov_data", ram_data, 32'hDEAD_BEEF);
      end
      @(negedge clk);
    end
    addr = IDLE_A;
    chk("we_low_cycles", 32'(wcnt), 32'd2);
    chk("busy_cycles", 32'(bcnt), 32'd3);
    rdchk("ram_read_back", 32'h0000_0010, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) begin
      a = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      wr(a, $urandom);
      wait_idle();
    end
    foreach (ref_mem[k])
      rdchk("ram_rand", {10'd0, 20'(k), 2'b00}, ref_mem[k]);

    wr(32'h0000_0100, 32'h1234_5678);
    @(negedge clk);
    addr = UART_DATA; din = 32'h99; is_write = 1'b1;
    @(negedge clk);
    is_write = 1'b0; addr = IDLE_A;
    wait_idle();
    cyc(10);
    rdchk("viol_stat", UART_STAT, 32'h1);
    rdchk("viol_ram", 32'h0000_0100, 32'h1234_5678);
    drain();

    wr(UART_DATA, 32'h41);
    chk("tx1_busy", {31'd0, busy}, 32'd0);
    wr(UART_DATA, 32'h42);
    chk("tx2_busy", {31'd0, busy}, 32'd0);
    drain();
    for (int i = 0; i < 10; i++) begin
      wr(UART_DATA, $urandom);
      wait_idle();
    end
    drain();

    hold = 1'b1;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      wr(UART_DATA, $urandom);
      chk("fill_busy", {31'd0, busy}, 32'd0);
      if (i == 2) rdchk("stat_3", UART_STAT, 32'h1);
    end
    rdchk("stat_full", UART_STAT, 32'h0);
    @(negedge clk);
    rx_data = 8'h5A; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_byte_ref = 8'h5A; rx_rdy = 1'b1;
    rdchk("stat_full_rx", UART_STAT, 32'h2);
    wr(UART_DATA, $urandom);
    chk("txwait_busy", {31'd0, busy}, 32'd1);
    cyc(4);
    chk("txwait_hold", {31'd0, busy}, 32'd1);
    rdchk("txwait_dout", UART_STAT, 32'h0);
    hold = 1'b0;
    wait_idle();
    drain();

    rdchk("stat_rx", UART_STAT, 32'h3);
    rdchk("rx_read", UART_DATA, 32'h5A);
    rx_rdy = 1'b0;
    rdchk("rx_cleared", UART_STAT, 32'h1);
    rdchk("rx_stale", UART_DATA, 32'h5A);
    rdchk("rx_stale_st", UART_STAT, 32'h1);
    @(negedge clk);
    rx_data = 8'h11; rx_valid = 1'b1;
    @(negedge clk);
    rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    rdchk("rx_overwrite", UART_DATA, 32'h22);
    rx_byte_ref = 8'h22;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      same = (i == 0) ? 1 : int'($urandom_range(0, 1));
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      if (same != 0) addr = UART_DATA;
      #1;
      if (same != 0) chk("rx_race_old", dout, {24'd0, rx_byte_ref});
      @(negedge clk);
      rx_valid = 1'b0; addr = IDLE_A;
      rx_byte_ref = b; rx_rdy = 1'b1;
      rdchk("rx_keep_st", UART_STAT, {30'd0, rx_rdy, 1'b1});
      rdchk("rx_data", UART_DATA, {24'd0, b});
      rx_rdy = 1'b0;
      rdchk("rx_clr_st", UART_STAT, 32'h1);
    end

    wr(32'h0000_0200, 32'hCAFE_F00D);
    chk("mid_we_low", {31'd0, we_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we_n", {31'd0, we_n}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    rdchk("rst_unmapped", IDLE_A, 32'h0);
    rdchk("rst_stat2", UART_STAT, 32'h1);
    rdchk("rst_rx_byte", UART_DATA, 32'h0);
    cyc(10);
    chk("tx_no_adjacent", 32'(adj_viol), 32'd0);
    chk("tx_none_extra", 32'(got_tx.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
